node_inject_queue: RTL and testbench



---
 rtl/node_inject_queue.sv | 115 +++++++++++
 tb/tb_node_inject_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/node_inject_queue.sv
// node_inject_queue: host-side injection stage feeding a oneDimensionalNode.
// Filters illegal destinations, optionally stamps the source field, buffers
// legal words in a FIFO and launches each as a single-cycle CS pulse with a
// guaranteed idle gap afterwards (the node cannot push back).
module node_inject_queue #(
  parameter logic [2:0] NODE_IP    = 3'b000,
  parameter int         NUM_NODES  = 5,
  parameter int         DEPTH      = 8,
  parameter int         GAP_CYCLES = 0,
  parameter bit         STAMP_SRC  = 1'b1
) (
  input  logic                   shiftInCLK,
  input  logic                   reset,
  input  logic [31:0]            hostData,
  input  logic                   hostWrite,
  input  logic                   injEnable,
  output logic                   hostFull,
  output logic [$clog2(DEPTH):0] hostCount,
  output logic [31:0]            injData,
  output logic                   injCS,
  output logic [7:0]             dropCount,
  output logic                   dropPulse,
  output logic                   ovfSticky
);

  localparam int AW = $clog2(DEPTH);
  // gapCnt only ever holds GAP_CYCLES-1
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {Idle, Send, Gap} stateT;

  stateT         state;
  logic [GW-1:0] gapCnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   countNext;
  logic [2:0]    dest;
  logic          illegal, pushOk, popOk;
  logic [31:0]   stamped;

  assign dest    = hostData[31:29];
  assign illegal = (dest == NODE_IP) || (32'(dest) >= 32'(NUM_NODES));
  // A full queue rejects even when a pop happens on the same edge.
  assign pushOk  = hostWrite && !illegal && !hostFull;
  assign popOk   = (state == Idle) && (hostCount != '0) && injEnable;
  assign stamped = {hostData[31:29], STAMP_SRC ? NODE_IP : hostData[28:26], hostData[25:0]};

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    countNext = hostCount;
    if (pushOk && !popOk)      countNext = hostCount + 1'b1;
    else if (!pushOk && popOk) countNext = hostCount - 1'b1;
  end

  // FIFO storage; no reset needed since pointers define validity.
  always_ff @(posedge shiftInCLK) begin
    if (!reset && pushOk) mem[wrPtr] <= stamped;
  end

  // Pointers, occupancy, filter statistics and overflow flag.
  always_ff @(posedge shiftInCLK) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      hostCount <= '0;
      hostFull  <= 1'b0;
      dropCount <= 8'd0;
      dropPulse <= 1'b0;
      ovfSticky <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      hostCount <= countNext;
      hostFull  <= (32'(countNext) == 32'(DEPTH));
      dropPulse <= hostWrite && illegal;
      if (hostWrite && illegal && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      if (hostWrite && !illegal && hostFull) ovfSticky <= 1'b1;
    end
  end

  // Injection sequencer: launch pulse, drop it, then hold off for the gap.
  always_ff @(posedge shiftInCLK) begin
    if (reset) begin
      state   <= Idle;
      gapCnt  <= '0;
      injCS   <= 1'b0;
      injData <= 32'd0;
    end else begin
      case (state)
        Idle: begin
          if (popOk) begin
            injData <= mem[rdPtr];
            injCS   <= 1'b1;
            state   <= Send;
          end
        end
        Send: begin
          injCS <= 1'b0;
          if (GAP_CYCLES == 0) begin
            state <= Idle;
          end else begin
            gapCnt <= GW'(GAP_CYCLES - 1);
            state  <= Gap;
          end
        end
        Gap: begin
          if (gapCnt == '0) state  <= Idle;
          else              gapCnt <= gapCnt - 1'b1;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_node_inject_queue.sv
// Directed bench for node_inject_queue: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences (overflow, ordering,
// spacing, gap, saturation, mid-operation reset).
module tb_node_inject_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hostData = 32'd0;
  logic        hostWrite = 1'b0;
  logic        injEnable = 1'b0;
  logic        hostFull;
  logic [3:0]  hostCount;
  logic [31:0] injData;
  logic        injCS;
  logic [7:0]  dropCount;
  logic        dropPulse;
  logic        ovfSticky;

  logic [31:0] gData = 32'd0;
  logic        gWr = 1'b0;
  logic        gEn = 1'b1;
  logic        gFull;
  logic [3:0]  gCount;
  logic [31:0] gInjData;
  logic        gCS;
  logic [7:0]  gDropCount;
  logic        gDropPulse;
  logic        gOvf;

  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  node_inject_queue dut (
    .shiftInCLK(clk), .reset(reset), .hostData(hostData), .hostWrite(hostWrite),
    .injEnable(injEnable), .hostFull(hostFull), .hostCount(hostCount),
    .injData(injData), .injCS(injCS), .dropCount(dropCount),
    .dropPulse(dropPulse), .ovfSticky(ovfSticky)
  );

  node_inject_queue #(.GAP_CYCLES(3)) dutGap (
    .shiftInCLK(clk), .reset(reset), .hostData(gData), .hostWrite(gWr),
    .injEnable(gEn), .hostFull(gFull), .hostCount(gCount),
    .injData(gInjData), .injCS(gCS), .dropCount(gDropCount),
    .dropPulse(gDropPulse), .ovfSticky(gOvf)
  );

  typedef struct {
    logic        wr;
    logic        en;
    logic [31:0] data;
    logic        expCS;
    logic [31:0] expData;
    logic [3:0]  expCount;
    logic        expFull;
    logic        expDp;
    logic [7:0]  expDc;
    logic        expOvf;
  } vecT;

  vecT vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    hostWrite = 1'b0;
    gWr = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int lastCyc;
    int firstG, secondG;
    logic [31:0] d [9];
    logic [31:0] g1, g2;

    // cycle-by-cycle vectors: single launch, then two filtered pushes
    vecs[0] = '{1'b1, 1'b1, 32'h90924924, 1'b0, 32'h00000000, 4'd1, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'h80924924, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 32'h80924924, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h10924924, 1'b0, 32'h80924924, 4'd0, 1'b0, 1'b1, 8'd1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'hA0000000, 1'b0, 32'h80924924, 4'd0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 32'h80924924, 4'd0, 1'b0, 1'b0, 8'd2, 1'b0};
    for (int i = 0; i < 9; i++) d[i] = 32'h20000000 | 32'(i * 32'h111);

    doReset();
    chk("rst injCS", 32'(injCS), 32'd0);
    chk("rst injData", injData, 32'd0);
    chk("rst hostCount", 32'(hostCount), 32'd0);
    chk("rst hostFull", 32'(hostFull), 32'd0);
    chk("rst dropCount", 32'(dropCount), 32'd0);
    chk("rst dropPulse", 32'(dropPulse), 32'd0);
    chk("rst ovfSticky", 32'(ovfSticky), 32'd0);

    for (int i = 0; i < 6; i++) begin
      hostWrite = vecs[i].wr;
      injEnable = vecs[i].en;
      hostData  = vecs[i].data;
      step();
      chk($sformatf("vec%0d injCS", i), 32'(injCS), 32'(vecs[i].expCS));
      chk($sformatf("vec%0d injData", i), injData, vecs[i].expData);
      chk($sformatf("vec%0d hostCount", i), 32'(hostCount), 32'(vecs[i].expCount));
      chk($sformatf("vec%0d hostFull", i), 32'(hostFull), 32'(vecs[i].expFull));
      chk($sformatf("vec%0d dropPulse", i), 32'(dropPulse), 32'(vecs[i].expDp));
      chk($sformatf("vec%0d dropCount", i), 32'(dropCount), 32'(vecs[i].expDc));
      chk($sformatf("vec%0d ovfSticky", i), 32'(ovfSticky), 32'(vecs[i].expOvf));
    end

    // fill with launches blocked, overflow on the ninth word
    injEnable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      hostWrite = 1'b1;
      hostData  = d[i];
      step();
      chk($sformatf("fill%0d hostCount", i), 32'(hostCount), (i < 8) ? 32'(i + 1) : 32'd8);
      chk($sformatf("fill%0d hostFull", i), 32'(hostFull), (i >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d ovfSticky", i), 32'(ovfSticky), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("ovf dropCount", 32'(dropCount), 32'd2);
    chk("ovf dropPulse", 32'(dropPulse), 32'd0);

    // drain: order and 2-cycle spacing
    hostWrite = 1'b0;
    injEnable = 1'b1;
    pulses = 0;
    lastCyc = -10;
    for (int c = 0; c < 40; c++) begin
      step();
      if (injCS) begin
        if (pulses < 8) chk($sformatf("drain%0d data", pulses), injData, d[pulses]);
        if (pulses > 0) chk($sformatf("drain%0d spacing", pulses), 32'(c - lastCyc), 32'd2);
        lastCyc = c;
        pulses++;
      end
    end
    chk("drain pulse count", 32'(pulses), 32'd8);
    chk("drain hostCount", 32'(hostCount), 32'd0);
    chk("drain hostFull", 32'(hostFull), 32'd0);

    // launch and legal push on the same edge
    injEnable = 1'b0;
    hostWrite = 1'b1;
    hostData  = 32'h40000AAA;
    step();
    chk("pp pre hostCount", 32'(hostCount), 32'd1);
    injEnable = 1'b1;
    hostData  = 32'h40000BBB;
    step();
    chk("pp hostCount", 32'(hostCount), 32'd1);
    chk("pp injCS", 32'(injCS), 32'd1);
    chk("pp injData", injData, 32'h40000AAA);
    hostWrite = 1'b0;
    for (int c = 0; c < 4; c++) step();

    // gap variant: rising edges 5 cycles apart
    doReset();
    gEn = 1'b1;
    gWr = 1'b1;
    gData = 32'h60000001;
    g1 = gData;
    step();
    gData = 32'h60000002;
    g2 = gData;
    firstG = -1;
    secondG = -1;
    for (int c = 1; c < 25; c++) begin
      step();
      gWr = 1'b0;
      if (gCS) begin
        if (firstG < 0) begin
          firstG = c;
          chk("gap first data", gInjData, g1);
        end else if (secondG < 0) begin
          secondG = c;
          chk("gap second data", gInjData, g2);
        end
      end
    end
    chk("gap first edge", 32'(firstG), 32'd1);
    chk("gap spacing", 32'(secondG - firstG), 32'd5);

    // saturation of the drop counter
    doReset();
    injEnable = 1'b1;
    hostData  = 32'h00000000;
    hostWrite = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) chk("sat 254", 32'(dropCount), 32'd254);
    end
    hostWrite = 1'b0;
    step();
    chk("sat 255", 32'(dropCount), 32'd255);
    chk("sat hostCount", 32'(hostCount), 32'd0);

    // reset during an in-flight pulse
    doReset();
    injEnable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hostWrite = 1'b1;
      hostData  = d[i];
      step();
    end
    hostWrite = 1'b0;
    injEnable = 1'b1;
    step();
    chk("mid injCS", 32'(injCS), 32'd1);
    chk("mid hostCount", 32'(hostCount), 32'd3);
    reset = 1'b1;
    hostWrite = 1'b1;
    hostData = d[5];
    step();
    chk("rstsend injCS", 32'(injCS), 32'd0);
    chk("rstsend hostCount", 32'(hostCount), 32'd0);
    chk("rstsend hostFull", 32'(hostFull), 32'd0);
    reset = 1'b0;
    hostWrite = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (injCS) pulses++;
    end
    chk("rstsend no pulses", 32'(pulses), 32'd0);
    chk("rstsend final hostCount", 32'(hostCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
